// File: rtl/pt_codes_pkg.sv
// Shared point-code, zone and debounce-state encodings for the hit judge and the score counter.
package pt_codes_pkg;

  typedef logic [3:0] pt_code_t;
  typedef logic [1:0] zone_t;
  typedef logic [1:0] deb_state_t;

  localparam pt_code_t PT_NONE  = 4'b0000;
  localparam pt_code_t PT_PLUS1 = 4'b0001;
  localparam pt_code_t PT_PLUS2 = 4'b0010;
  localparam pt_code_t PT_NEG2  = 4'b1110;

  localparam zone_t ZONE_NONE    = 2'b00;
  localparam zone_t ZONE_NEAR    = 2'b01;
  localparam zone_t ZONE_PERFECT = 2'b10;

  localparam deb_state_t DEB_UP        = 2'd0;
  localparam deb_state_t DEB_DOWN_PEND = 2'd1;
  localparam deb_state_t DEB_DOWN      = 2'd2;
  localparam deb_state_t DEB_UP_PEND   = 2'd3;

  function automatic logic pt_is_hit(input pt_code_t code);
    return (code == PT_PLUS1) || (code == PT_PLUS2);
  endfunction

endpackage

// File: rtl/lane_judge.sv
// One judge lane: key synchroniser, debounce FSM, scored flag and registered point code.
module lane_judge
  import pt_codes_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [1:0] zone,
  input  logic       arrow_new,
  input  logic       arrow_exit,
  output logic [3:0] pt,
  output logic [3:0] pt_next
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1_q, sync1_d, sync2_q, sync2_d;
  logic       hold1_q, hold2_q;
  deb_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rel_cnt_q, rel_cnt_d;
  logic       lock_q, lock_d;
  logic       flag_q, flag_d;
  pt_code_t   pt_q, pt_d;

  logic pressed;
  logic press_evt;
  logic flag_mid;

  // Free-running sampler that tells reset whether the key was being held going into it.
  always_ff @(posedge clk) begin
    hold1_q <= ~key_n;
    hold2_q <= hold1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= DEB_UP;
      cnt_q     <= 8'd0;
      rel_cnt_q <= 8'd0;
      lock_q    <= hold2_q;
      flag_q    <= 1'b0;
      pt_q      <= PT_NONE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_cnt_q <= rel_cnt_d;
      lock_q    <= lock_d;
      flag_q    <= flag_d;
      pt_q      <= pt_d;
    end
  end

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  assign pressed = ~sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      DEB_UP: begin
        if (pressed) begin
          state_d = DEB_DOWN_PEND;
          cnt_d   = 8'd0;
        end
      end
      DEB_DOWN_PEND: begin
        if (!pressed) begin
          state_d = DEB_UP;
          cnt_d   = 8'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = DEB_DOWN;
          cnt_d     = 8'd0;
          press_evt = ~lock_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DEB_DOWN: begin
        if (!pressed) begin
          state_d = DEB_UP_PEND;
          cnt_d   = 8'd0;
        end
      end
      DEB_UP_PEND: begin
        if (pressed) begin
          state_d = DEB_DOWN;
          cnt_d   = 8'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = DEB_UP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = DEB_UP;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // A key held through reset stays mute until it has been released for DEB_CYCLES samples.
  always_comb begin
    lock_d    = lock_q;
    rel_cnt_d = rel_cnt_q;
    if (lock_q) begin
      if (pressed) begin
        rel_cnt_d = 8'd0;
      end else if (rel_cnt_q == DEB_LAST) begin
        lock_d    = 1'b0;
        rel_cnt_d = 8'd0;
      end else begin
        rel_cnt_d = rel_cnt_q + 8'd1;
      end
    end
  end

  // Exit is judged on the old flag, then a new arrow clears it, then the press is judged.
  always_comb begin
    flag_mid = arrow_new ? 1'b0 : flag_q;
    flag_d   = flag_mid;
    pt_d     = PT_NONE;
    if (press_evt) begin
      if (!flag_mid && zone == ZONE_PERFECT) begin
        pt_d   = PT_PLUS2;
        flag_d = 1'b1;
      end else if (!flag_mid && zone == ZONE_NEAR) begin
        pt_d   = PT_PLUS1;
        flag_d = 1'b1;
      end else begin
        pt_d = PT_NEG2;
      end
    end else if (arrow_exit && !flag_q) begin
      pt_d = PT_NEG2;
    end
  end

  assign pt      = pt_q;
  assign pt_next = pt_d;

endmodule

// File: rtl/pt_judge.sv
// Four-lane hit judge: per-lane point codes plus a saturating combo (streak) counter.
module pt_judge
  import pt_codes_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned COMBO_MAX  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic [1:0] zone_0,
  input  logic [1:0] zone_1,
  input  logic [1:0] zone_2,
  input  logic [1:0] zone_3,
  input  logic [3:0] arrow_new,
  input  logic [3:0] arrow_exit,
  output logic [3:0] pt_0,
  output logic [3:0] pt_1,
  output logic [3:0] pt_2,
  output logic [3:0] pt_3,
  output logic [6:0] combo
);

  localparam logic [7:0] COMBO_MAX_W = 8'(COMBO_MAX);

  logic [1:0] zone_w [4];
  logic [3:0] pt_w [4];
  logic [3:0] pt_next_w [4];

  logic [6:0] combo_q, combo_d;
  logic [7:0] hits;
  logic [7:0] sum;
  logic       any_neg;

  assign zone_w[0] = zone_0;
  assign zone_w[1] = zone_1;
  assign zone_w[2] = zone_2;
  assign zone_w[3] = zone_3;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_judge #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .key_n     (key_n[i]),
      .zone      (zone_w[i]),
      .arrow_new (arrow_new[i]),
      .arrow_exit(arrow_exit[i]),
      .pt        (pt_w[i]),
      .pt_next   (pt_next_w[i])
    );
  end

  // Combo follows the codes being registered this edge, so it reads the lanes' next codes.
  always_comb begin
    any_neg = 1'b0;
    hits    = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (pt_next_w[i] == PT_NEG2) begin
        any_neg = 1'b1;
      end
      if (pt_is_hit(pt_next_w[i])) begin
        hits = hits + 8'd1;
      end
    end
    sum = {1'b0, combo_q} + hits;
    if (any_neg) begin
      combo_d = 7'd0;
    end else if (sum > COMBO_MAX_W) begin
      combo_d = COMBO_MAX_W[6:0];
    end else begin
      combo_d = sum[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      combo_q <= 7'd0;
    end else begin
      combo_q <= combo_d;
    end
  end

  assign pt_0  = pt_w[0];
  assign pt_1  = pt_w[1];
  assign pt_2  = pt_w[2];
  assign pt_3  = pt_w[3];
  assign combo = combo_q;

endmodule
